// File: rtl/hssl_link_ctrl_pkg.sv
// Shared types and sizing helpers for the HSSL link bring-up sequencer.
package hssl_link_ctrl_pkg;

  localparam int STATE_W    = 3;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [STATE_W-1:0] {
    RST_TX    = 3'd0,
    WAIT_TX   = 3'd1,
    RST_RX    = 3'd2,
    WAIT_RX   = 3'd3,
    WAIT_SYNC = 3'd4,
    LINK_UP   = 3'd5
  } link_state_e;

  // The shared state counter only ever holds values below the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hssl_sync_bit.sv
// Multi-flop level synchroniser for one asynchronous input bit.
module hssl_sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d_in,
  output logic q_out
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d_in};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[DEPTH-1];

endmodule

// File: rtl/hssl_link_ctrl.sv
// Reset sequencer and link supervisor for one HSSL transceiver channel.
// Optional statistics outputs are enabled by defining HSSL_LINK_STATS_EN.
module hssl_link_ctrl
  import hssl_link_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int DONE_TIMEOUT_CYC = 1048576,
  parameter int SYNC_TIMEOUT_CYC = 1048576,
  parameter int ERR_WINDOW_CYC   = 1024,
  parameter int ERR_THRESHOLD    = 8
) (
  input  logic               freerun_clk_in,
  input  logic               reset_all_in,
  input  logic               tx_reset_done_in,
  input  logic               rx_reset_done_in,
  input  logic               rx_aligned_in,
  input  logic               rx_err_toggle_in,
  output logic               tx_reset_datapath_out,
  output logic               rx_reset_datapath_out,
  output logic               tx_elecidle_out,
  output logic               link_up_out,
  output logic [STATE_W-1:0] state_out
`ifdef HSSL_LINK_STATS_EN
  ,
  output logic [15:0]        link_drops_out,
  output logic [31:0]        err_total_out
`endif
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, DONE_TIMEOUT_CYC, SYNC_TIMEOUT_CYC);
  localparam int WIN_W = (ERR_WINDOW_CYC > 1) ? $clog2(ERR_WINDOW_CYC) : 1;
  localparam int ERR_W = $clog2(ERR_THRESHOLD + 1);

  // Limits are "last cycle in state": dwell equals the configured cycle count.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_TIMEOUT_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(ERR_WINDOW_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_THR    = ERR_W'(ERR_THRESHOLD);

  logic [3:0] async_vec;
  logic [3:0] sync_vec;
  logic       tx_done_s, rx_done_s, aligned_s, err_s;

  assign async_vec = {rx_err_toggle_in, rx_aligned_in, rx_reset_done_in, tx_reset_done_in};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    hssl_sync_bit #(.DEPTH(SYNC_DEPTH)) u_sync (
      .clk   (freerun_clk_in),
      .srst  (reset_all_in),
      .d_in  (async_vec[gi]),
      .q_out (sync_vec[gi])
    );
  end

  assign tx_done_s = sync_vec[0];
  assign rx_done_s = sync_vec[1];
  assign aligned_s = sync_vec[2];
  assign err_s     = sync_vec[3];

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_base;
  logic             err_prev_q, err_prev_d;
  logic             tx_rst_q, tx_rst_d;
  logic             rx_rst_q, rx_rst_d;
  logic             idle_q, idle_d;
  logic             link_up_q, link_up_d;
  logic             in_link, win_wrap, err_evt, err_hit;

  // Error-rate window: only live in LINK_UP, so both counters start at zero on entry.
  always_comb begin
    err_prev_d = err_s;
    in_link    = (state_q == LINK_UP);
    win_wrap   = in_link && (win_q == WIN_LAST);
    err_evt    = in_link && (err_s != err_prev_q);
    win_d      = '0;
    if (in_link && !win_wrap) begin
      win_d = win_q + WIN_W'(1);
    end
    err_base  = win_wrap ? '0 : err_cnt_q;
    err_cnt_d = '0;
    if (in_link) begin
      err_cnt_d = err_base;
      if (err_evt && (err_base < ERR_THR)) begin
        err_cnt_d = err_base + ERR_W'(1);
      end
    end
    err_hit = (err_cnt_d >= ERR_THR);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      RST_TX: begin
        if (cnt_q == PULSE_LAST) state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_s)               state_d = RST_RX;
        else if (cnt_q == DONE_LAST) state_d = RST_TX;
      end
      RST_RX: begin
        if (cnt_q == PULSE_LAST) state_d = WAIT_RX;
      end
      WAIT_RX: begin
        if (rx_done_s)               state_d = WAIT_SYNC;
        else if (cnt_q == DONE_LAST) state_d = RST_TX;
      end
      WAIT_SYNC: begin
        if (aligned_s)               state_d = LINK_UP;
        else if (cnt_q == SYNC_LAST) state_d = RST_TX;
      end
      LINK_UP: begin
        cnt_d = cnt_q;
        if (!tx_done_s)                 state_d = RST_TX;
        else if (!aligned_s || err_hit) state_d = RST_RX;
      end
      default: begin
        state_d = RST_TX;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    // Outputs are registered off the next state so they move with state_out.
    tx_rst_d  = (state_d == RST_TX);
    rx_rst_d  = (state_d == RST_TX) || (state_d == RST_RX);
    idle_d    = (state_d == RST_TX) || (state_d == WAIT_TX);
    link_up_d = (state_d == LINK_UP);
  end

  always_ff @(posedge freerun_clk_in) begin
    if (reset_all_in) begin
      state_q    <= RST_TX;
      cnt_q      <= '0;
      win_q      <= '0;
      err_cnt_q  <= '0;
      err_prev_q <= 1'b0;
      tx_rst_q   <= 1'b1;
      rx_rst_q   <= 1'b1;
      idle_q     <= 1'b1;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      err_cnt_q  <= err_cnt_d;
      err_prev_q <= err_prev_d;
      tx_rst_q   <= tx_rst_d;
      rx_rst_q   <= rx_rst_d;
      idle_q     <= idle_d;
      link_up_q  <= link_up_d;
    end
  end

  assign tx_reset_datapath_out = tx_rst_q;
  assign rx_reset_datapath_out = rx_rst_q;
  assign tx_elecidle_out       = idle_q;
  assign link_up_out           = link_up_q;
  assign state_out             = state_q;

`ifdef HSSL_LINK_STATS_EN
  logic [15:0] drops_q, drops_d;
  logic [31:0] errs_q, errs_d;

  always_comb begin
    drops_d = drops_q;
    errs_d  = errs_q;
    if (in_link && (state_d != LINK_UP) && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
    if (err_evt && (errs_q != 32'hFFFF_FFFF)) begin
      errs_d = errs_q + 32'd1;
    end
  end

  always_ff @(posedge freerun_clk_in) begin
    if (reset_all_in) begin
      drops_q <= '0;
      errs_q  <= '0;
    end else begin
      drops_q <= drops_d;
      errs_q  <= errs_d;
    end
  end

  assign link_drops_out = drops_q;
  assign err_total_out  = errs_q;
`endif

endmodule
